// File: rtl/sobel_fifo_rd_ctrl_if.sv
// rtl/sobel_fifo_rd_ctrl_if.sv - pixel output stream between the FIFO read sequencer and the Sobel window
interface sobel_fifo_rd_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int COL_WIDTH  = 8,
  parameter int ROW_WIDTH  = 8
);
  logic [DATA_WIDTH-1:0] pix_data_out;
  logic                  pix_valid_out;
  logic                  pix_ready_in;
  logic                  sof_out;
  logic                  eol_out;
  logic                  eof_out;
  logic [COL_WIDTH-1:0]  col_out;
  logic [ROW_WIDTH-1:0]  row_out;

  // Producer side: the read sequencer drives pixels and tags, samples ready
  modport master (
    output pix_data_out,
    output pix_valid_out,
    output sof_out,
    output eol_out,
    output eof_out,
    output col_out,
    output row_out,
    input  pix_ready_in
  );

  // Consumer side: the window pipeline accepts pixels and drives ready
  modport slave (
    input  pix_data_out,
    input  pix_valid_out,
    input  sof_out,
    input  eol_out,
    input  eof_out,
    input  col_out,
    input  row_out,
    output pix_ready_in
  );
endinterface

// File: rtl/sobel_fifo_rd_ctrl.sv
// rtl/sobel_fifo_rd_ctrl.sv - read-side sequencer popping the pixel FIFO into a tagged valid/ready stream
module sobel_fifo_rd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 256,
  parameter int IMG_HEIGHT = 256,
  parameter int COL_WIDTH  = 8,
  parameter int ROW_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_in,
  input  logic [DATA_WIDTH-1:0] fifo_data_in,
  input  logic                  fifo_empty_in,
  input  logic                  fifo_overflow_in,
  output logic                  fifo_rd_ack_out,
  sobel_fifo_rd_ctrl_if.master  pix,
  output logic                  busy_out,
  output logic                  frame_done_out,
  output logic                  error_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    LAST   = 2'd2,
    FLUSH  = 2'd3
  } state_t;

  localparam logic [COL_WIDTH-1:0] LAST_COL = COL_WIDTH'(IMG_WIDTH - 1);
  localparam logic [ROW_WIDTH-1:0] LAST_ROW = ROW_WIDTH'(IMG_HEIGHT - 1);

  state_t                state;
  logic [COL_WIDTH-1:0]  col_cnt;
  logic [ROW_WIDTH-1:0]  row_cnt;

  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  sof_q;
  logic                  eol_q;
  logic                  eof_q;
  logic [COL_WIDTH-1:0]  col_q;
  logic [ROW_WIDTH-1:0]  row_q;
  logic                  done_q;
  logic                  error_q;

  logic                  out_free;
  logic                  accept;
  logic                  load;
  logic                  at_last_col;
  logic                  at_last_row;

  // Output register is free when empty or being drained this cycle; a pop
  // happens only while streaming, the FIFO has data and no overflow/reset
  always_comb begin
    out_free    = !valid_q || pix.pix_ready_in;
    accept      = valid_q && pix.pix_ready_in;
    at_last_col = (col_cnt == LAST_COL);
    at_last_row = (row_cnt == LAST_ROW);
    load        = reset && (state == STREAM) && !fifo_empty_in &&
                  out_free && !fifo_overflow_in;
  end

  // Frame sequencer: state, position counters, output register and flags
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      col_cnt <= '0;
      row_cnt <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start_in) begin
            state   <= STREAM;
            col_cnt <= '0;
            row_cnt <= '0;
            error_q <= 1'b0;
          end
        end

        STREAM: begin
          if (fifo_overflow_in) begin
            // Held pixel belongs to a corrupted frame: drop it
            state   <= FLUSH;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
            col_cnt <= '0;
            row_cnt <= '0;
          end else if (load) begin
            data_q  <= fifo_data_in;
            valid_q <= 1'b1;
            col_q   <= col_cnt;
            row_q   <= row_cnt;
            sof_q   <= (col_cnt == '0) && (row_cnt == '0);
            eol_q   <= at_last_col;
            eof_q   <= at_last_col && at_last_row;
            if (at_last_col && at_last_row) begin
              // Frame fully popped; counters park at zero for the next one
              col_cnt <= '0;
              row_cnt <= '0;
              state   <= LAST;
            end else if (at_last_col) begin
              col_cnt <= '0;
              row_cnt <= row_cnt + 1'b1;
            end else begin
              col_cnt <= col_cnt + 1'b1;
            end
          end else if (accept) begin
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
          end
        end

        LAST: begin
          if (fifo_overflow_in) begin
            state   <= FLUSH;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
          end else if (accept) begin
            // End-of-frame pixel has left; report completion once
            state   <= IDLE;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
            done_q  <= 1'b1;
          end
        end

        FLUSH: begin
          valid_q <= 1'b0;
          sof_q   <= 1'b0;
          eol_q   <= 1'b0;
          eof_q   <= 1'b0;
          col_cnt <= '0;
          row_cnt <= '0;
          if (start_in) begin
            state   <= STREAM;
            error_q <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase

      // Overflow wins the error flag over a same-cycle start
      if (fifo_overflow_in) begin
        error_q <= 1'b1;
      end
    end
  end

  // Drive the stream interface and status from registered state
  always_comb begin
    pix.pix_data_out  = data_q;
    pix.pix_valid_out = valid_q;
    pix.sof_out       = sof_q;
    pix.eol_out       = eol_q;
    pix.eof_out       = eof_q;
    pix.col_out       = col_q;
    pix.row_out       = row_q;
    fifo_rd_ack_out   = load;
    busy_out          = (state != IDLE);
    frame_done_out    = done_q;
    error_out         = error_q;
  end

endmodule

// File: tb/tb_sobel_fifo_rd_ctrl.sv
// tb/tb_sobel_fifo_rd_ctrl.sv - self-checking bench for the Sobel FIFO read sequencer
module tb_sobel_fifo_rd_ctrl;
  localparam int DW   = 8;
  localparam int W    = 4;
  localparam int H    = 2;
  localparam int CW   = 2;
  localparam int RW   = 1;
  localparam int NPIX = W * H;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_in;
  logic [DW-1:0] fifo_data_in;
  logic          fifo_empty_in;
  logic          fifo_overflow_in;
  logic          fifo_rd_ack_out;
  logic          busy_out;
  logic          frame_done_out;
  logic          error_out;

  sobel_fifo_rd_ctrl_if #(.DATA_WIDTH(DW), .COL_WIDTH(CW), .ROW_WIDTH(RW)) pix_if ();

  sobel_fifo_rd_ctrl #(
    .DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .COL_WIDTH(CW), .ROW_WIDTH(RW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start_in         (start_in),
    .fifo_data_in     (fifo_data_in),
    .fifo_empty_in    (fifo_empty_in),
    .fifo_overflow_in (fifo_overflow_in),
    .fifo_rd_ack_out  (fifo_rd_ack_out),
    .pix              (pix_if),
    .busy_out         (busy_out),
    .frame_done_out   (frame_done_out),
    .error_out        (error_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] fq[$];
  logic [7:0] sq[$];
  bit   hold_empty;
  int   k, n_acc, n_ack, cyc, first_acc, last_acc;
  bit   exp_done, done_seen, prev_stall;
  logic [DW-1:0] ps_data;
  logic [CW-1:0] ps_col;
  logic [RW-1:0] ps_row;
  logic [2:0]    ps_tags;

  task automatic clear_model();
    fq.delete();
    sq.delete();
    k = 0; n_acc = 0; n_ack = 0;
    exp_done = 0; prev_stall = 0; first_acc = -1; last_acc = -1;
    hold_empty = 0;
  endtask

  task automatic push_pix(input logic [7:0] v);
    fq.push_back(v);
    sq.push_back(v);
  endtask

  task automatic tick();
    logic ack, acc, vld, rdy;
    int e_col, e_row;
    fifo_empty_in = (fq.size() == 0) || hold_empty;
    fifo_data_in  = (fq.size() != 0) ? fq[0] : '0;
    #1;
    vld = pix_if.pix_valid_out;
    rdy = pix_if.pix_ready_in;
    ack = fifo_rd_ack_out;
    acc = vld && rdy;
    checks++;
    if (frame_done_out !== exp_done) begin
      failures++;
      $display("FAIL frame_done: got %0b exp %0b", frame_done_out, exp_done);
    end
    if (frame_done_out === 1'b1) begin
      done_seen = 1;
      checks++;
      if (busy_out !== 1'b0) begin
        failures++;
        $display("FAIL busy_at_done: got %0b exp 0", busy_out);
      end
    end
    if (prev_stall) begin
      checks++;
      if (vld !== 1'b1 || pix_if.pix_data_out !== ps_data || pix_if.col_out !== ps_col ||
          pix_if.row_out !== ps_row ||
          {pix_if.sof_out, pix_if.eol_out, pix_if.eof_out} !== ps_tags) begin
        failures++;
        $display("FAIL stall_hold: got v=%0b d=%0h c=%0d r=%0d exp v=1 d=%0h c=%0d r=%0d",
                 vld, pix_if.pix_data_out, pix_if.col_out, pix_if.row_out, ps_data, ps_col, ps_row);
      end
    end
    if (ack) begin
      checks++;
      if (fifo_empty_in || fifo_overflow_in || !reset || (vld && !rdy)) begin
        failures++;
        $display("FAIL rd_ack: got ack=1 with empty=%0b ovf=%0b reset=%0b valid=%0b ready=%0b exp ack=0",
                 fifo_empty_in, fifo_overflow_in, reset, vld, rdy);
      end
    end
    exp_done = 0;
    prev_stall = vld && !rdy && reset && !fifo_overflow_in;
    ps_data = pix_if.pix_data_out;
    ps_col  = pix_if.col_out;
    ps_row  = pix_if.row_out;
    ps_tags = {pix_if.sof_out, pix_if.eol_out, pix_if.eof_out};
    if (acc && reset && !fifo_overflow_in) begin
      e_col = k % W;
      e_row = k / W;
      checks++;
      if (sq.size() == 0) begin
        failures++;
        $display("FAIL extra_pixel: got d=%0h exp none", pix_if.pix_data_out);
      end else if (pix_if.pix_data_out !== sq[0] || pix_if.col_out !== CW'(e_col) ||
                   pix_if.row_out !== RW'(e_row) ||
                   pix_if.sof_out !== (k == 0) || pix_if.eol_out !== (e_col == W - 1) ||
                   pix_if.eof_out !== (k == NPIX - 1)) begin
        failures++;
        $display("FAIL pixel: got d=%0h c=%0d r=%0d sof=%0b eol=%0b eof=%0b exp d=%0h c=%0d r=%0d sof=%0b eol=%0b eof=%0b",
                 pix_if.pix_data_out, pix_if.col_out, pix_if.row_out, pix_if.sof_out,
                 pix_if.eol_out, pix_if.eof_out, sq[0], e_col, e_row, (k == 0),
                 (e_col == W - 1), (k == NPIX - 1));
      end
      if (sq.size() != 0) void'(sq.pop_front());
      if (first_acc < 0) first_acc = cyc;
      last_acc = cyc;
      n_acc++;
      if (k == NPIX - 1) begin
        exp_done = 1;
        k = 0;
      end else begin
        k++;
      end
    end
    @(posedge clk);
    if (ack && reset && fq.size() != 0) begin
      void'(fq.pop_front());
      n_ack++;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_until_done(input int budget, input bit rnd);
    done_seen = 0;
    for (int i = 0; i < budget && !done_seen; i++) begin
      if (rnd) begin
        pix_if.pix_ready_in = ($urandom_range(0, 3) != 0);
        hold_empty = ($urandom_range(0, 3) == 0);
      end
      tick();
    end
    pix_if.pix_ready_in = 1'b1;
    hold_empty = 0;
    checks++;
    if (!done_seen) begin
      failures++;
      $display("FAIL done_timeout: got no frame_done in %0d cycles exp pulse", budget);
    end
  endtask

  task automatic run_until_acc(input int n, input int budget);
    for (int i = 0; i < budget && n_acc < n; i++) tick();
    checks++;
    if (n_acc < n) begin
      failures++;
      $display("FAIL acc_timeout: got %0d accepts exp %0d", n_acc, n);
    end
  endtask

  task automatic pulse_start();
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
  endtask

  task automatic check_count(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d exp %0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    checks++;
    if (pix_if.pix_valid_out !== 1'b0 || pix_if.pix_data_out !== '0 || pix_if.col_out !== '0 ||
        pix_if.row_out !== '0 || pix_if.sof_out !== 1'b0 || pix_if.eol_out !== 1'b0 ||
        pix_if.eof_out !== 1'b0 || busy_out !== 1'b0 || frame_done_out !== 1'b0 ||
        error_out !== 1'b0 || fifo_rd_ack_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got v=%0b d=%0h c=%0d r=%0d busy=%0b done=%0b err=%0b ack=%0b exp all 0",
               pix_if.pix_valid_out, pix_if.pix_data_out, pix_if.col_out, pix_if.row_out,
               busy_out, frame_done_out, error_out, fifo_rd_ack_out);
    end
  endtask

  task automatic test_basic();
    clear_model();
    for (int i = 0; i < NPIX; i++) push_pix(8'h10 + 8'(i));
    pulse_start();
    run_until_done(40, 0);
    check_count("basic_accepts", n_acc, NPIX);
    check_count("basic_rd_acks", n_ack, NPIX);
    check_count("basic_span", last_acc - first_acc, NPIX - 1);
  endtask

  task automatic test_ready_toggle();
    clear_model();
    for (int i = 0; i < NPIX; i++) push_pix(8'h10 + 8'(i));
    pulse_start();
    done_seen = 0;
    for (int i = 0; i < 100 && !done_seen; i++) begin
      pix_if.pix_ready_in = (i % 3 == 0);
      tick();
    end
    pix_if.pix_ready_in = 1'b1;
    check_count("toggle_done", int'(done_seen), 1);
    check_count("toggle_accepts", n_acc, NPIX);
    check_count("toggle_rd_acks", n_ack, NPIX);
  endtask

  task automatic test_empty_gap();
    clear_model();
    push_pix(8'h10);
    push_pix(8'h11);
    pulse_start();
    run_until_acc(2, 20);
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (pix_if.pix_valid_out !== 1'b0) begin
      failures++;
      $display("FAIL gap_valid: got %0b exp 0", pix_if.pix_valid_out);
    end
    check_count("gap_rd_acks", n_ack, 2);
    for (int i = 2; i < NPIX; i++) push_pix(8'h10 + 8'(i));
    run_until_done(40, 0);
    check_count("gap_accepts", n_acc, NPIX);
  endtask

  task automatic test_overflow();
    int acks_before;
    clear_model();
    for (int i = 0; i < NPIX; i++) push_pix(8'h10 + 8'(i));
    pulse_start();
    run_until_acc(5, 30);
    acks_before = n_ack;
    fifo_overflow_in = 1'b1;
    tick();
    fifo_overflow_in = 1'b0;
    check_count("ovf_no_pop", n_ack, acks_before);
    checks++;
    if (pix_if.pix_valid_out !== 1'b0 || error_out !== 1'b1 || busy_out !== 1'b1) begin
      failures++;
      $display("FAIL ovf_state: got v=%0b err=%0b busy=%0b exp v=0 err=1 busy=1",
               pix_if.pix_valid_out, error_out, busy_out);
    end
    clear_model();
    for (int i = 0; i < NPIX; i++) push_pix(8'h20 + 8'(i));
    for (int i = 0; i < 3; i++) tick();
    check_count("flush_no_pop", n_ack, 0);
    checks++;
    if (pix_if.pix_valid_out !== 1'b0 || error_out !== 1'b1) begin
      failures++;
      $display("FAIL flush_hold: got v=%0b err=%0b exp v=0 err=1", pix_if.pix_valid_out, error_out);
    end
    pulse_start();
    checks++;
    if (error_out !== 1'b0) begin
      failures++;
      $display("FAIL ovf_restart_err: got %0b exp 0", error_out);
    end
    run_until_done(40, 0);
    check_count("ovf_restart_accepts", n_acc, NPIX);
  endtask

  task automatic test_start_overflow_idle();
    clear_model();
    start_in = 1'b1;
    fifo_overflow_in = 1'b1;
    tick();
    start_in = 1'b0;
    fifo_overflow_in = 1'b0;
    checks++;
    if (busy_out !== 1'b1 || error_out !== 1'b1) begin
      failures++;
      $display("FAIL start_ovf_idle: got busy=%0b err=%0b exp busy=1 err=1", busy_out, error_out);
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++;
    if (busy_out !== 1'b0 || error_out !== 1'b0) begin
      failures++;
      $display("FAIL start_ovf_reset: got busy=%0b err=%0b exp 0 0", busy_out, error_out);
    end
  endtask

  task automatic test_reset_mid();
    clear_model();
    for (int i = 0; i < NPIX; i++) push_pix(8'h40 + 8'(i));
    pulse_start();
    run_until_acc(2, 20);
    pulse_start();
    run_until_acc(6, 20);
    checks++;
    if (pix_if.pix_valid_out !== 1'b1 || pix_if.col_out !== CW'(2) || pix_if.row_out !== RW'(1) ||
        pix_if.pix_data_out !== 8'h46) begin
      failures++;
      $display("FAIL mid_position: got v=%0b c=%0d r=%0d d=%0h exp v=1 c=2 r=1 d=46",
               pix_if.pix_valid_out, pix_if.col_out, pix_if.row_out, pix_if.pix_data_out);
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    clear_model();
    checks++;
    if (pix_if.pix_valid_out !== 1'b0 || pix_if.pix_data_out !== '0 || pix_if.col_out !== '0 ||
        pix_if.row_out !== '0 || pix_if.sof_out !== 1'b0 || pix_if.eol_out !== 1'b0 ||
        pix_if.eof_out !== 1'b0 || busy_out !== 1'b0 || frame_done_out !== 1'b0 ||
        error_out !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: got v=%0b d=%0h c=%0d r=%0d busy=%0b exp all 0",
               pix_if.pix_valid_out, pix_if.pix_data_out, pix_if.col_out, pix_if.row_out, busy_out);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 4; f++) begin
      clear_model();
      for (int i = 0; i < NPIX; i++) push_pix(8'($urandom_range(0, 255)));
      pulse_start();
      run_until_done(300, 1);
      check_count("rand_accepts", n_acc, NPIX);
      check_count("rand_rd_acks", n_ack, NPIX);
    end
  endtask

  initial begin
    reset = 1'b0;
    start_in = 1'b0;
    fifo_overflow_in = 1'b0;
    fifo_empty_in = 1'b1;
    fifo_data_in = '0;
    pix_if.pix_ready_in = 1'b1;
    cyc = 0;
    clear_model();
    @(negedge clk);
    test_reset();
    test_basic();
    test_ready_toggle();
    test_empty_gap();
    test_overflow();
    test_start_overflow_idle();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sobel_fifo_rd_ctrl.md
Name: sobel_fifo_rd_ctrl

Overview:
- Read-side sequencer for the 8-bit RAM pixel FIFO that feeds the Sobel window pipeline.
- Pops pixels from the FIFO's show-ahead read port and presents them on a registered valid/ready stream.
- Tracks column and row across one IMG_WIDTH x IMG_HEIGHT frame and tags pixels with start-of-frame, end-of-line and end-of-frame.
- On FIFO overflow it flushes, flags the error, and waits for the next frame start.

Parameters:
DATA_WIDTH, 8, pixel width; matches the FIFO data width
IMG_WIDTH, 256, pixels per line (>=2)
IMG_HEIGHT, 256, lines per frame (>=2)
COL_WIDTH, 8, column counter width; 2^COL_WIDTH >= IMG_WIDTH
ROW_WIDTH, 8, row counter width; 2^ROW_WIDTH >= IMG_HEIGHT

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous reset, active-low (0 = reset)
start_in  in  1  single-cycle pulse; begin a frame
fifo_data_in  in  DATA_WIDTH  FIFO show-ahead data (valid when fifo_empty_in=0)
fifo_empty_in  in  1  FIFO empty flag
fifo_overflow_in  in  1  FIFO overflow flag (FIFO has self-cleared)
fifo_rd_ack_out  out  1  FIFO pop strobe, combinational
pix_data_out  out  DATA_WIDTH  registered pixel
pix_valid_out  out  1  pixel valid
pix_ready_in  in  1  downstream accepts when valid&ready
sof_out  out  1  qualifies pix_data_out: row 0, column 0
eol_out  out  1  qualifies pix_data_out: column IMG_WIDTH-1
eof_out  out  1  qualifies pix_data_out: last pixel of frame
col_out  out  COL_WIDTH  column of pix_data_out
row_out  out  ROW_WIDTH  row of pix_data_out
busy_out  out  1  state != IDLE
frame_done_out  out  1  one-cycle pulse after the eof pixel is accepted
error_out  out  1  sticky overflow flag; cleared by reset or start_in

Behaviour:
- Reset (reset=0 at clk edge):
  - State = IDLE; internal column and row counters = 0.
  - Outputs: pix_valid_out=0, pix_data_out=0, sof/eol/eof=0, col_out=0, row_out=0, frame_done_out=0, error_out=0.
  - Reset takes priority over everything, mid-frame included; any held pixel is discarded.
- States:
  - IDLE: start_in -> STREAM, counters=0, error_out cleared.
  - STREAM: loads pixels (see load rule). After loading the eof pixel -> LAST. fifo_overflow_in=1 -> FLUSH.
  - LAST: no loads. When the held eof pixel is accepted -> IDLE, frame_done_out=1 for one cycle. fifo_overflow_in=1 -> FLUSH.
  - FLUSH: pix_valid_out=0, counters=0, fifo_rd_ack_out=0. start_in -> STREAM and clears error_out.
- Load rule:
  - load = (state==STREAM) & !fifo_empty_in & (!pix_valid_out | pix_ready_in) & !fifo_overflow_in.
  - fifo_rd_ack_out = load; it never asserts when fifo_empty_in=1.
  - On load:
    - pix_data_out <= fifo_data_in; pix_valid_out <= 1.
    - col_out/row_out <= counter values.
    - sof/eol/eof <= decoded from the counter values.
    - Counters advance: col wraps IMG_WIDTH-1 -> 0 and increments row; the eof load leaves the counters at 0.
  - If valid&ready and no load: pix_valid_out <= 0, and sof/eol/eof <= 0.
  - Otherwise the output register holds; data and tags stay stable while valid & !ready.
- Latency: the pixel at FIFO head at edge N appears on the outputs after edge N. Sustained 1 pixel/clk with ready held at 1 and the FIFO non-empty.
- Overflow:
  - fifo_overflow_in=1 in STREAM or LAST: error_out <= 1, pix_valid_out <= 0, state <= FLUSH, no pop that cycle.
  - In IDLE or FLUSH: only error_out <= 1.
- Simultaneous events:
  - overflow beats load.
  - start_in outside IDLE/FLUSH is ignored.
  - start_in and fifo_overflow_in together in IDLE: -> STREAM and error_out=1, because overflow wins the flag.
  - reset beats all.
- Counter compares are exact equality against IMG_WIDTH-1 and IMG_HEIGHT-1; no arithmetic overflow of the counters.

Test Plan:
- IMG 4x2, FIFO pre-filled with 8 pixels 0x10..0x17, ready=1, start pulse -> 8 consecutive valid cycles:
  - sof on 0x10; eol on 0x13 and 0x17; eof on 0x17.
  - frame_done one cycle after 0x17 is accepted; busy falls with it; 8 rd_ack pulses total.
- Same frame, ready toggling 1,0,0,1,... -> no pixel lost or duplicated; data/col/row stable while valid&!ready; rd_ack only when the output register is free.
- FIFO empty for 3 cycles mid-line after pixel 0x11 -> valid drops once 0x11 is accepted; no rd_ack while empty; resumes with 0x12 at col 2, row 0.
- fifo_overflow_in pulse at pixel 5 -> valid=0 next cycle, error_out=1, FLUSH; no rd_ack. A later start pulse clears error, and the next pixel carries sof with col=0, row=0.
- reset=0 for one cycle mid-frame (col 2, row 1) -> all outputs at reset values, IDLE, busy=0. start_in during STREAM is ignored: the count continues uninterrupted.
